// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds the PC in offset form, reads instruction memory over req/ready,
// and feeds decode through an output register with a one-entry skid buffer.
module pc_fetch_unit #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter logic [31:0] RESET_OFFSET = 32'h0000_0000,
  parameter int          IM_WORDS     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [11:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] LAST_OFFSET = 32'(4 * IM_WORDS - 4);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        pend_redir;
  logic [11:0] hold_addr;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        xfer;
  logic        out_free;
  logic [31:0] pc_next4;

  function automatic logic legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc <= LAST_OFFSET);
  endfunction

  assign im_req   = (state == S_WAIT);
  // A pending redirect has already replaced pc_q, so the outstanding request keeps its old address.
  assign im_addr  = pend_redir ? hold_addr : pc_q[13:2];
  assign xfer     = im_req && im_ready && !pend_redir;
  assign out_free = !if_valid || !stall;
  assign pc_next4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      pc_q        <= RESET_OFFSET;
      pend_redir  <= 1'b0;
      hold_addr   <= 12'd0;
      skid_valid  <= 1'b0;
      skid_instr  <= 32'd0;
      skid_pc     <= 32'd0;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
      pc_q       <= redirect_pc;
      case (state)
        S_WAIT: begin
          if (im_ready) begin
            pend_redir <= 1'b0;
            state      <= S_IDLE;
          end else if (!pend_redir) begin
            pend_redir <= 1'b1;
            hold_addr  <= pc_q[13:2];
          end
        end
        S_FAULT: begin
          if (legal(redirect_pc)) begin
            fetch_fault <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      if (xfer) begin
        pc_q <= pc_next4;
        if (out_free) begin
          if_valid <= 1'b1;
          if_instr <= im_rdata;
          if_pc    <= pc_q + BASE_ADDR;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= im_rdata;
          skid_pc    <= pc_q + BASE_ADDR;
        end
      end else if (!stall) begin
        if (skid_valid) begin
          if_valid   <= 1'b1;
          if_instr   <= skid_instr;
          if_pc      <= skid_pc;
          skid_valid <= 1'b0;
        end else begin
          if_valid <= 1'b0;
        end
      end

      case (state)
        S_BOOT: state <= S_IDLE;
        S_IDLE: begin
          if (!legal(pc_q)) begin
            fetch_fault <= 1'b1;
            state       <= S_FAULT;
          end else if (!skid_valid) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (im_ready) begin
            if (pend_redir) begin
              pend_redir <= 1'b0;
              state      <= S_IDLE;
            end else if (out_free && legal(pc_next4)) begin
              state <= S_WAIT;
            end else begin
              // Skid just filled or the next PC is illegal; IDLE sorts out which.
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; memory returns word k = 0x1000_0000 + k.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [11:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ready       (im_ready),
    .im_rdata       (im_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  assign im_rdata = 32'h1000_0000 + {20'd0, im_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return if_valid;
      1:       return fetch_fault;
      default: return im_req;
    endcase
  endfunction

  // sel: 0 = if_valid, 1 = fetch_fault, 2 = im_req
  task automatic wait_for(input string tag, input int sel);
    int n = 0;
    while (cond(sel) !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'd0, cond(sel)}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    im_ready       = 1'b1;
    #1;
    chk("rst_im_req",   {31'd0, im_req},      32'd0);
    chk("rst_if_valid", {31'd0, if_valid},    32'd0);
    chk("rst_if_instr", if_instr,             32'd0);
    chk("rst_if_pc",    if_pc,                32'd0);
    chk("rst_fault",    {31'd0, fetch_fault}, 32'd0);

    // zero-wait streaming from reset
    do_reset();
    step();
    chk("boot_no_req", {31'd0, im_req}, 32'd0);
    step();
    chk("req_cycle2", {31'd0, im_req}, 32'd1);
    chk("req_addr0",  {20'd0, im_addr}, 32'd0);
    step();
    chk("s1_pc",    if_pc,    32'h0000_3000);
    chk("s1_instr", if_instr, 32'h1000_0000);
    step();
    chk("s2_pc",    if_pc,    32'h0000_3004);
    chk("s2_valid", {31'd0, if_valid}, 32'd1);
    step();
    chk("s3_pc",    if_pc,    32'h0000_3008);
    chk("s3_instr", if_instr, 32'h1000_0002);

    // three-cycle wait state
    im_ready = 1'b0;
    do_reset();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",  {31'd0, im_req},   32'd1);
      chk("ws_addr", {20'd0, im_addr},  32'd0);
      chk("ws_nov",  {31'd0, if_valid}, 32'd0);
      if (i < 2) step();
    end
    im_ready = 1'b1;
    step();
    chk("ws_instr", if_instr, 32'h1000_0000);
    chk("ws_pc",    if_pc,    32'h0000_3000);
    im_ready = 1'b0;
    step();
    chk("ws_next_addr", {20'd0, im_addr}, 32'd1);
    chk("ws_drain",     {31'd0, if_valid}, 32'd0);

    // stall for 4 cycles after the first instruction
    im_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    chk("st_first", if_pc, 32'h0000_3000);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_hold_pc",  if_pc,             32'h0000_3000);
      chk("st_hold_req", {31'd0, im_req},   32'd0);
      chk("st_hold_v",   {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("st_skid_pc",    if_pc,    32'h0000_3004);
    chk("st_skid_instr", if_instr, 32'h1000_0001);
    step();
    wait_for("st_next_wait", 0);
    chk("st_next_pc",    if_pc,    32'h0000_3008);
    chk("st_next_instr", if_instr, 32'h1000_0002);

    // redirect while waiting on offset 0x8
    do_reset();
    step();
    step();
    step();
    step();
    im_ready = 1'b0;
    step();
    chk("rd_wait_addr", {20'd0, im_addr}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    chk("rd_hold_addr", {20'd0, im_addr},  32'd2);
    chk("rd_hold_req",  {31'd0, im_req},   32'd1);
    chk("rd_flush",     {31'd0, if_valid}, 32'd0);
    step();
    chk("rd_hold_addr2", {20'd0, im_addr}, 32'd2);
    im_ready = 1'b1;
    step();
    chk("rd_discard", {31'd0, if_valid}, 32'd0);
    chk("rd_idle",    {31'd0, im_req},   32'd0);
    step();
    chk("rd_new_req",  {31'd0, im_req},  32'd1);
    chk("rd_new_addr", {20'd0, im_addr}, 32'd16);
    step();
    chk("rd_pc",    if_pc,    32'h0000_3040);
    chk("rd_instr", if_instr, 32'h1000_0010);

    // misaligned redirect faults, legal redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    wait_for("ft_wait", 1);
    chk("ft_req", {31'd0, im_req},   32'd0);
    chk("ft_v",   {31'd0, if_valid}, 32'd0);
    step();
    chk("ft_sticky", {31'd0, fetch_fault}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    step();
    redirect_valid = 1'b0;
    chk("ft_clear", {31'd0, fetch_fault}, 32'd0);
    wait_for("ft_rec_wait", 0);
    chk("ft_rec_pc",    if_pc,    32'h0000_3010);
    chk("ft_rec_instr", if_instr, 32'h1000_0004);

    // last legal word, then run off the end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3FFC;
    step();
    redirect_valid = 1'b0;
    wait_for("end_wait", 0);
    chk("end_pc",    if_pc,    32'h0000_6FFC);
    chk("end_instr", if_instr, 32'h1000_0FFF);
    wait_for("end_fault", 1);
    chk("end_req", {31'd0, im_req}, 32'd0);

    // asynchronous reset in the middle of a WAIT
    im_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    step();
    redirect_valid = 1'b0;
    wait_for("ar_req_wait", 2);
    im_ready = 1'b1;
    stall    = 1'b1;
    step();
    im_ready = 1'b0;
    step();
    chk("ar_pre_req", {31'd0, im_req},   32'd1);
    chk("ar_pre_v",   {31'd0, if_valid}, 32'd1);
    chk("ar_pre_pc",  if_pc,             32'h0000_3000);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req",   {31'd0, im_req},      32'd0);
    chk("ar_v",     {31'd0, if_valid},    32'd0);
    chk("ar_instr", if_instr,             32'd0);
    chk("ar_pc",    if_pc,                32'd0);
    chk("ar_fault", {31'd0, fetch_fault}, 32'd0);
    chk("ar_addr",  {20'd0, im_addr},     32'd0);
    step();
    reset = 1'b0;
    stall = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
